// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// rtc_pkg : register map, bit positions and defaults for the RTC controller
// Rev 1.0
// ============================================================================
package rtc_pkg;

    localparam int unsigned RTC_TICK_DIV_DEFAULT = 25;

    localparam logic [1:0] RTC_A_SECONDS = 2'd0;
    localparam logic [1:0] RTC_A_ALARM   = 2'd1;
    localparam logic [1:0] RTC_A_CTRL    = 2'd2;
    localparam logic [1:0] RTC_A_STATUS  = 2'd3;

    localparam int unsigned RTC_CTRL_RUN      = 0;
    localparam int unsigned RTC_CTRL_ALARM_IE = 1;
    localparam int unsigned RTC_CTRL_SEC_IE   = 2;

    localparam int unsigned RTC_STAT_ALARM = 0;
    localparam int unsigned RTC_STAT_SEC   = 1;

endpackage
`default_nettype wire

// File: rtl/rtc_prescaler.sv
`default_nettype none
// ============================================================================
// rtc_prescaler : divides clk by TICK_DIV into a registered one-cycle tick
// Rev 1.0
// ============================================================================
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = RTC_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int unsigned           c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0]    c_last  = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_pcnt;
    logic               r_tick;

    // restart takes priority so a load never coincides with a tick
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else if (run) begin
            if (r_pcnt == c_last) begin
                r_pcnt <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pcnt <= r_pcnt + c_cnt_w'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/rtc_ctrl.sv
`default_nettype none
// ============================================================================
// rtc_ctrl : register front-end, load sequencing and interrupts for rtc_counter
// Rev 1.0
// ============================================================================
module rtc_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = RTC_TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  reg_addr,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        rd_valid,
    output logic        tick_1us,
    output logic        rtc_wr_en,
    output logic [31:0] rtc_data,
    input  logic [31:0] rtc_seconds,
    output logic        irq
);

    logic        w_wr_sec;
    logic        w_wr_alarm;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_inc;
    logic        w_alarm_hit;
    logic [1:0]  w_clr;
    logic [31:0] w_rd_mux;

    logic [31:0] r_alarm;
    logic [31:0] r_sec_q;
    logic [31:0] r_data;
    logic [31:0] r_rdata;
    logic        r_run;
    logic        r_alarm_ie;
    logic        r_sec_ie;
    logic        r_alarm_pend;
    logic        r_sec_pend;
    logic        r_wr_en;
    logic        r_wr_en_q;
    logic        r_rd_valid;
    logic        r_irq;

    assign w_wr_sec   = reg_wr && (reg_addr == RTC_A_SECONDS);
    assign w_wr_alarm = reg_wr && (reg_addr == RTC_A_ALARM);
    assign w_wr_ctrl  = reg_wr && (reg_addr == RTC_A_CTRL);
    assign w_wr_stat  = reg_wr && (reg_addr == RTC_A_STATUS);

    assign w_clr[RTC_STAT_ALARM] = w_wr_stat && reg_wdata[RTC_STAT_ALARM];
    assign w_clr[RTC_STAT_SEC]   = w_wr_stat && reg_wdata[RTC_STAT_SEC];

    // a change right after our own load strobe is the load landing, not a count
    assign w_inc       = (rtc_seconds != r_sec_q) && !r_wr_en_q;
    assign w_alarm_hit = w_inc && (rtc_seconds == r_alarm);

    always_comb begin
        w_rd_mux = '0;
        case (reg_addr)
            RTC_A_SECONDS: w_rd_mux = rtc_seconds;
            RTC_A_ALARM:   w_rd_mux = r_alarm;
            RTC_A_CTRL: begin
                w_rd_mux[RTC_CTRL_RUN]      = r_run;
                w_rd_mux[RTC_CTRL_ALARM_IE] = r_alarm_ie;
                w_rd_mux[RTC_CTRL_SEC_IE]   = r_sec_ie;
            end
            default: begin
                w_rd_mux[RTC_STAT_ALARM] = r_alarm_pend;
                w_rd_mux[RTC_STAT_SEC]   = r_sec_pend;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid   <= 1'b0;
            r_rdata      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_en_q    <= 1'b0;
            r_data       <= '0;
            r_alarm      <= '0;
            r_run        <= 1'b1;
            r_alarm_ie   <= 1'b0;
            r_sec_ie     <= 1'b0;
            r_sec_q      <= '0;
            r_alarm_pend <= 1'b0;
            r_sec_pend   <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            // read mux samples pre-write state, so rd+wr returns the old value
            r_rd_valid <= reg_rd;
            r_rdata    <= reg_rd ? w_rd_mux : '0;
            r_wr_en    <= w_wr_sec;
            r_wr_en_q  <= r_wr_en;
            if (w_wr_sec) begin
                r_data <= reg_wdata;
            end
            if (w_wr_alarm) begin
                r_alarm <= reg_wdata;
            end
            if (w_wr_ctrl) begin
                r_run      <= reg_wdata[RTC_CTRL_RUN];
                r_alarm_ie <= reg_wdata[RTC_CTRL_ALARM_IE];
                r_sec_ie   <= reg_wdata[RTC_CTRL_SEC_IE];
            end
            r_sec_q      <= rtc_seconds;
            r_alarm_pend <= w_alarm_hit || (r_alarm_pend && !w_clr[RTC_STAT_ALARM]);
            r_sec_pend   <= w_inc || (r_sec_pend && !w_clr[RTC_STAT_SEC]);
            r_irq        <= (r_alarm_pend && r_alarm_ie) || (r_sec_pend && r_sec_ie);
        end
    end

    rtc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (r_run),
        .restart (w_wr_sec),
        .tick    (tick_1us)
    );

    assign reg_rdata = r_rdata;
    assign rd_valid  = r_rd_valid;
    assign rtc_wr_en = r_wr_en;
    assign rtc_data  = r_data;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_rtc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rtc_ctrl : self-checking bench for rtc_ctrl with a behavioural counter model
// Rev 1.0
// ============================================================================
module tb_rtc_ctrl;
    import rtc_pkg::*;

    localparam int unsigned TD = 25;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  reg_addr;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        rd_valid;
    logic        tick_1us;
    logic        rtc_wr_en;
    logic [31:0] rtc_data;
    logic [31:0] rtc_seconds = '0;
    logic        irq;
    logic        bump;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] want;
    } vec_t;
    vec_t tbl[12];

    // reference model state for the random phase
    logic [31:0] m_alarm, e_rdata, e_data, rv, s_wdata;
    logic        m_run, m_aie, m_sie, m_ap, m_sp;
    logic        e_rdv, e_wr, e_irq, e_tick, inc_pend, cur_inc, ap_hit;
    logic        s_wr, s_rd, s_bump;
    logic [1:0]  s_addr, clr;
    int          m_runs;

    rtc_ctrl #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg_addr    (reg_addr),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .rd_valid    (rd_valid),
        .tick_1us    (tick_1us),
        .rtc_wr_en   (rtc_wr_en),
        .rtc_data    (rtc_data),
        .rtc_seconds (rtc_seconds),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // sibling rtc_counter: load has priority over a count
    always @(posedge clk) begin
        if (!rst_n)         rtc_seconds <= '0;
        else if (rtc_wr_en) rtc_seconds <= rtc_data;
        else if (bump)      rtc_seconds <= rtc_seconds + 32'd1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, want);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0; reg_wdata = '0;
    endtask

    task automatic reg_read(input logic [1:0] a, input string name, input logic [31:0] want);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_rd = 1'b0;
        chk({name, " valid"}, 32'(rd_valid), 32'd1);
        chk(name, reg_rdata, want);
    endtask

    task automatic wait_tick(input int bound, output int cnt);
        cnt = 0;
        while (!tick_1us && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
        if (!tick_1us) begin
            n_checks++;
            n_errors++;
            $display("FAIL tick timeout: got no tick_1us in %0d cycles, required a tick", bound);
        end
    endtask

    initial begin
        rst_n = 1'b0; reg_addr = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_wdata = '0; bump = 1'b0;

        tbl[0]  = '{1'b0, RTC_A_CTRL,    32'h0,         32'h1};
        tbl[1]  = '{1'b0, RTC_A_ALARM,   32'h0,         32'h0};
        tbl[2]  = '{1'b0, RTC_A_STATUS,  32'h0,         32'h0};
        tbl[3]  = '{1'b0, RTC_A_SECONDS, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, RTC_A_ALARM,   32'hDEADBEEF,  32'h0};
        tbl[5]  = '{1'b0, RTC_A_ALARM,   32'h0,         32'hDEADBEEF};
        tbl[6]  = '{1'b1, RTC_A_CTRL,    32'hFFFFFFFF,  32'h0};
        tbl[7]  = '{1'b0, RTC_A_CTRL,    32'h0,         32'h7};
        tbl[8]  = '{1'b1, RTC_A_CTRL,    32'h00000001,  32'h0};
        tbl[9]  = '{1'b0, RTC_A_CTRL,    32'h0,         32'h1};
        tbl[10] = '{1'b1, RTC_A_ALARM,   32'h0,         32'h0};
        tbl[11] = '{1'b0, RTC_A_ALARM,   32'h0,         32'h0};

        // strobes during reset must not produce anything
        repeat (3) @(negedge clk);
        reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = RTC_A_SECONDS; reg_wdata = 32'h55;
        @(negedge clk);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset rdata", reg_rdata, 32'd0);
        chk("reset wr_en", 32'(rtc_wr_en), 32'd0);
        chk("reset rtc_data", rtc_data, 32'd0);
        chk("reset tick", 32'(tick_1us), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        reg_wr = 1'b0; reg_rd = 1'b0; reg_wdata = '0;
        rst_n = 1'b1;

        wait_tick(100, n);
        chk("first tick after reset", n, TD);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("tick width", 32'(tick_1us), 32'd0);
            wait_tick(100, n);
            chk("tick period", n + 1, TD);
        end

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) reg_write(tbl[i].addr, tbl[i].data);
            else           reg_read(tbl[i].addr, $sformatf("tbl[%0d]", i), tbl[i].want);
        end

        // load lands exactly where a natural tick was due
        wait_tick(100, n);
        repeat (TD - 1) @(negedge clk);
        reg_write(RTC_A_SECONDS, 32'd100);
        chk("load wr_en", 32'(rtc_wr_en), 32'd1);
        chk("load data", rtc_data, 32'd100);
        chk("load tick suppressed", 32'(tick_1us), 32'd0);
        @(negedge clk);
        chk("load wr_en one cycle", 32'(rtc_wr_en), 32'd0);
        wait_tick(100, n);
        chk("tick after load (cycles from reg_wr)", n + 2, TD + 1);
        reg_read(RTC_A_STATUS, "status after load", 32'd0);
        reg_read(RTC_A_SECONDS, "seconds readback", 32'd100);

        // alarm match on an increment
        reg_write(RTC_A_ALARM, 32'd5);
        reg_write(RTC_A_CTRL, 32'd3);
        reg_write(RTC_A_SECONDS, 32'd4);
        repeat (2) @(negedge clk);
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        chk("alarm irq M", 32'(irq), 32'd0);
        @(negedge clk);
        chk("alarm irq M+1", 32'(irq), 32'd0);
        @(negedge clk);
        chk("alarm irq M+2", 32'(irq), 32'd1);
        reg_read(RTC_A_STATUS, "alarm status", 32'd3);
        reg_write(RTC_A_STATUS, 32'd1);
        chk("w1c irq W+1", 32'(irq), 32'd1);
        @(negedge clk);
        chk("w1c irq W+2", 32'(irq), 32'd0);
        reg_read(RTC_A_STATUS, "after alarm w1c", 32'd2);
        reg_write(RTC_A_STATUS, 32'd3);

        // loading the alarm value is not an alarm
        reg_write(RTC_A_ALARM, 32'd7);
        reg_write(RTC_A_SECONDS, 32'd7);
        repeat (3) @(negedge clk);
        chk("load==alarm irq", 32'(irq), 32'd0);
        reg_read(RTC_A_STATUS, "load==alarm status", 32'd0);

        // wrap is an increment; set beats a same-cycle clear
        reg_write(RTC_A_CTRL, 32'd5);
        reg_write(RTC_A_SECONDS, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        repeat (2) @(negedge clk);
        reg_read(RTC_A_STATUS, "wrap status", 32'd2);
        chk("wrap irq", 32'(irq), 32'd1);
        reg_write(RTC_A_STATUS, 32'd2);
        @(negedge clk);
        reg_read(RTC_A_STATUS, "sec w1c", 32'd0);
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        reg_write(RTC_A_STATUS, 32'd2);
        reg_read(RTC_A_STATUS, "set beats w1c", 32'd2);
        reg_write(RTC_A_STATUS, 32'd3);
        reg_write(RTC_A_CTRL, 32'd1);

        // RUN=0 freezes the phase
        wait_tick(100, n);
        reg_write(RTC_A_CTRL, 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (tick_1us) n++;
            @(negedge clk);
        end
        chk("ticks while stopped", n, 0);
        reg_write(RTC_A_CTRL, 32'd1);
        wait_tick(100, n);
        chk("tick after restart run", n + 1, TD);

        // simultaneous read and write
        reg_write(RTC_A_ALARM, 32'd3);
        reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = RTC_A_ALARM; reg_wdata = 32'd9;
        @(negedge clk);
        reg_rd = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
        chk("rd+wr valid", 32'(rd_valid), 32'd1);
        chk("rd+wr old value", reg_rdata, 32'd3);
        reg_read(RTC_A_ALARM, "rd+wr new value", 32'd9);

        // reset in the middle of a load request
        reg_write(RTC_A_CTRL, 32'd5);
        bump = 1'b1;
        @(negedge clk);
        bump = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset irq", 32'(irq), 32'd1);
        rst_n = 1'b0; reg_wr = 1'b1; reg_addr = RTC_A_SECONDS; reg_wdata = 32'd77;
        @(negedge clk);
        reg_wr = 1'b0; reg_wdata = '0;
        chk("reset drops wr_en", 32'(rtc_wr_en), 32'd0);
        chk("reset clears irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(100, n);
        chk("phase restart after reset", n, TD);

        // randomized run against the reference model
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_alarm = '0; m_run = 1'b1; m_aie = 1'b0; m_sie = 1'b0; m_ap = 1'b0; m_sp = 1'b0;
        m_runs = 0; inc_pend = 1'b0;
        e_rdv = 1'b0; e_rdata = '0; e_wr = 1'b0; e_data = '0; e_irq = 1'b0; e_tick = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd rd_valid", 32'(rd_valid), 32'(e_rdv));
            if (e_rdv) chk("rnd rdata", reg_rdata, e_rdata);
            chk("rnd wr_en", 32'(rtc_wr_en), 32'(e_wr));
            if (e_wr) chk("rnd rtc_data", rtc_data, e_data);
            chk("rnd irq", 32'(irq), 32'(e_irq));
            chk("rnd tick", 32'(tick_1us), 32'(e_tick));

            s_wr   = ($urandom_range(0, 9) == 0);
            s_rd   = ($urandom_range(0, 3) == 0);
            s_addr = 2'($urandom_range(0, 3));
            s_bump = ($urandom_range(0, 3) == 0);
            if (s_addr == RTC_A_SECONDS && $urandom_range(0, 2) != 0) s_wr = 1'b0;
            case (s_addr)
                RTC_A_SECONDS: s_wdata = 32'($urandom_range(0, 20));
                RTC_A_ALARM:   s_wdata = rtc_seconds + 32'($urandom_range(1, 3));
                RTC_A_CTRL: begin
                    s_wdata = $urandom;
                    if ($urandom_range(0, 4) != 0) s_wdata[0] = 1'b1;
                end
                default:       s_wdata = $urandom;
            endcase

            case (s_addr)
                RTC_A_SECONDS: rv = rtc_seconds;
                RTC_A_ALARM:   rv = m_alarm;
                RTC_A_CTRL:    rv = {29'd0, m_sie, m_aie, m_run};
                default:       rv = {30'd0, m_sp, m_ap};
            endcase

            // an increment shows up the cycle after a bump that was not overridden by a load
            cur_inc  = inc_pend;
            inc_pend = s_bump && !e_wr;
            ap_hit   = cur_inc && (rtc_seconds == m_alarm);
            e_irq    = (m_ap && m_aie) || (m_sp && m_sie);
            e_rdv    = s_rd;
            e_rdata  = rv;
            e_wr     = s_wr && (s_addr == RTC_A_SECONDS);
            if (e_wr) e_data = s_wdata;
            e_tick   = !e_wr && m_run && (((m_runs + 1) % TD) == 0);
            if (e_wr)       m_runs = 0;
            else if (m_run) m_runs = m_runs + 1;
            clr  = (s_wr && s_addr == RTC_A_STATUS) ? s_wdata[1:0] : 2'b00;
            m_ap = ap_hit  || (m_ap && !clr[0]);
            m_sp = cur_inc || (m_sp && !clr[1]);
            if (s_wr && s_addr == RTC_A_ALARM) m_alarm = s_wdata;
            if (s_wr && s_addr == RTC_A_CTRL) begin
                m_run = s_wdata[0]; m_aie = s_wdata[1]; m_sie = s_wdata[2];
            end

            reg_wr = s_wr; reg_rd = s_rd; reg_addr = s_addr; reg_wdata = s_wdata; bump = s_bump;
            @(negedge clk);
        end
        reg_wr = 1'b0; reg_rd = 1'b0; bump = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
